// File: rtl/regfile_pkg.sv
// Shared sizes and types for the 32-entry register file.
package regfile_pkg;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [4:0]  ZERO_REG   = 5'd0;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/reg32.sv
// One storage word with write enable and asynchronous active-low clear.
module reg32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;
endmodule

// File: rtl/reg_file32.sv
// 32 x DATA_WIDTH register file: two combinational read ports, one clocked write port, r0 fixed at zero.
module reg_file32
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);
  localparam int unsigned REG_COUNT = 2 ** ADDR_WIDTH;

  logic [REG_COUNT-1:1]  we_c;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  // Write decoder; slot 0 has no enable so r0 writes vanish.
  always_comb begin
    we_c = '0;
    for (int unsigned i = 1; i < REG_COUNT; i++) begin
      we_c[i] = RegWrite && (WriteReg == ADDR_WIDTH'(i))
                && (WriteReg != ADDR_WIDTH'(ZERO_REG));
    end
  end

  assign regs[0] = '0;

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_reg
    reg32 #(.WIDTH(DATA_WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (reset),
      .en    (we_c[g]),
      .d     (WriteData),
      .q     (regs[g])
    );
  end

  // Read muxes read straight off the storage outputs; no write bypass.
  assign ReadData1 = regs[ReadReg1];
  assign ReadData2 = regs[ReadReg2];
endmodule

// File: tb/tb_reg_file32.sv
// Directed self-checking bench for reg_file32.
module tb_reg_file32;
  import regfile_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1, ReadData2;

  int checks = 0;
  int errors = 0;

  reg_file32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteData (WriteData),
    .WriteReg  (WriteReg),
    .RegWrite  (RegWrite),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    logic [31:0] base;
    base = 32'h0101_0101;
    return (i == 0) ? 32'h0 : base * 32'(i);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = 5'd3; ReadReg2 = 5'd27;

    // reset held for two cycles
    repeat (2) @(negedge clk);
    chk("reset_rd1_a", ReadData1, 32'h0);
    chk("reset_rd2_a", ReadData2, 32'h0);
    ReadReg1 = 5'($urandom_range(31)); ReadReg2 = 5'($urandom_range(31));
    #1;
    chk("reset_rd1_rand", ReadData1, 32'h0);
    chk("reset_rd2_rand", ReadData2, 32'h0);

    // release, first edge with reset=1 accepts write to r5
    @(negedge clk);
    reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEAD_BEEF;
    ReadReg1 = 5'd5;
    @(posedge clk); #1;
    chk("r5_written", ReadData1, 32'hDEAD_BEEF);
    RegWrite = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("r5_async_clear", ReadData1, 32'h0);

    // basic write/read
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = 5'd16; WriteData = 32'hAAAA_FFFF;
    @(negedge clk);
    RegWrite = 1'b0;
    ReadReg1 = 5'd16; ReadReg2 = 5'd8;
    #1;
    chk("basic_r16", ReadData1, 32'hAAAA_FFFF);
    chk("basic_r8", ReadData2, 32'h0);

    // r0 write discarded
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hAAAA_FFFF;
    repeat (3) @(negedge clk);
    RegWrite = 1'b0; ReadReg2 = 5'd0;
    #1;
    chk("r0_zero", ReadData2, 32'h0);
    chk("r0_r16_kept", ReadData1, 32'hAAAA_FFFF);

    // write enable low
    WriteReg = 5'd16; WriteData = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("we_low_r16", ReadData1, 32'hAAAA_FFFF);

    // fill r1..r31
    for (int i = 1; i < 32; i++) begin
      RegWrite = 1'b1; WriteReg = 5'(i); WriteData = sweep_val(i);
      @(negedge clk);
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      #1;
      chk($sformatf("sweep_rd1_%0d", i), ReadData1, sweep_val(i));
      chk($sformatf("sweep_rd2_%0d", 31 - i), ReadData2, sweep_val(31 - i));
    end
    ReadReg1 = 5'd12; ReadReg2 = 5'd12;
    #1;
    chk("same_addr_rd1", ReadData1, 32'h0C0C_0C0C);
    chk("same_addr_rd2", ReadData2, 32'h0C0C_0C0C);

    // read-during-write on r7
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h1;
    @(negedge clk);
    ReadReg1 = 5'd7; WriteData = 32'h2;
    #1;
    chk("rdw_before", ReadData1, 32'h1);
    @(posedge clk); #1;
    chk("rdw_after", ReadData1, 32'h2);

    // write during reset is ignored
    @(negedge clk);
    reset = 1'b0; WriteReg = 5'd9; WriteData = 32'h3;
    ReadReg2 = 5'd9;
    @(negedge clk);
    RegWrite = 1'b0; reset = 1'b1;
    #1;
    chk("r9_blocked", ReadData2, 32'h0);
    chk("r7_lost", ReadData1, 32'h0);
    @(negedge clk);
    chk("r9_after_edge", ReadData2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
